// File: rtl/sopc_reset_seq.sv
// Reset and run-control sequencer: synchronises the board reset, releases NUM_CH domains in a staggered order,
// then drives the core clock enable. Define RUN_LIMIT_EN to add the run budget and the HALT state.
module sopc_reset_seq #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned HOLD_CYCLES = 5,
  parameter int unsigned STAGGER     = 2,
  parameter int unsigned RUN_CYCLES  = 50,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req,
  input  logic              halt_clr,
  output logic [NUM_CH-1:0] rst_out,
  output logic              ce,
  output logic              halt,
  output logic              busy,
  output logic [CNT_W-1:0]  run_cnt
);

  typedef enum logic [1:0] {
    SYNC,
    HOLD,
    RUN,
    HALT
  } state_e;

  localparam logic [CNT_W-1:0] LastRel = CNT_W'(HOLD_CYCLES + (NUM_CH - 1) * STAGGER);

  state_e            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic [NUM_CH-1:0] rst_out_q, rst_out_d;
  logic              ce_q, ce_d;
  logic              busy_q, busy_d;

`ifdef RUN_LIMIT_EN
  localparam logic [CNT_W-1:0] RunLimit = CNT_W'(RUN_CYCLES);
  logic halt_q, halt_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{halt_clr, CNT_W'(RUN_CYCLES)};
`endif

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[0], 1'b1};
    hold_cnt_d = hold_cnt_q;
    run_cnt_d  = run_cnt_q;
    rst_out_d  = rst_out_q;

    unique case (state_q)
      SYNC: begin
        // Leave on the edge where the synchroniser output first goes high.
        if (sync_q[0] && !sync_q[1]) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (hold_cnt_d == CNT_W'(HOLD_CYCLES + k * STAGGER)) begin
            rst_out_d[k] = 1'b0;
          end
        end
        if (hold_cnt_d == LastRel) begin
          state_d   = RUN;
          run_cnt_d = '0;
        end
      end
      RUN: begin
        run_cnt_d = run_cnt_q + CNT_W'(1);
`ifdef RUN_LIMIT_EN
        if (run_cnt_d == RunLimit) begin
          state_d = HALT;
        end
`endif
      end
      HALT: begin
`ifdef RUN_LIMIT_EN
        if (halt_clr) begin
          state_d   = RUN;
          run_cnt_d = '0;
        end
`endif
      end
      default: begin
        state_d = SYNC;
      end
    endcase

    // Software reset overrides the resume and run-limit decisions above.
    if (sw_rst_req && (state_q != SYNC)) begin
      state_d    = HOLD;
      hold_cnt_d = '0;
      run_cnt_d  = '0;
      rst_out_d  = '1;
    end

    busy_d = (state_d == SYNC) || (state_d == HOLD);
    ce_d   = (state_d == RUN);
`ifdef RUN_LIMIT_EN
    halt_d = (state_d == HALT);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SYNC;
      sync_q     <= '0;
      hold_cnt_q <= '0;
      run_cnt_q  <= '0;
      rst_out_q  <= '1;
      ce_q       <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hold_cnt_q <= hold_cnt_d;
      run_cnt_q  <= run_cnt_d;
      rst_out_q  <= rst_out_d;
      ce_q       <= ce_d;
      busy_q     <= busy_d;
    end
  end

`ifdef RUN_LIMIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end
  assign halt = halt_q;
`else
  assign halt = 1'b0;
`endif

  assign rst_out = rst_out_q;
  assign ce      = ce_q;
  assign busy    = busy_q;
  assign run_cnt = run_cnt_q;

endmodule

// File: tb/tb_sopc_reset_seq.sv
// Scoreboard bench for sopc_reset_seq: stimulus queues expected per-cycle outputs, a monitor checks them on negedges.
module tb_sopc_reset_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst1 = 1'b0, sw1 = 1'b0, hc1 = 1'b0;
  logic [1:0]  ro1;
  logic        ce1, halt1, busy1;
  logic [15:0] rc1;

  logic        rst2 = 1'b0, sw2 = 1'b0, hc2 = 1'b0;
  logic [3:0]  ro2;
  logic        ce2, halt2, busy2;
  logic [3:0]  rc2;

  sopc_reset_seq dut1 (
    .clk(clk), .rst(rst1), .sw_rst_req(sw1), .halt_clr(hc1),
    .rst_out(ro1), .ce(ce1), .halt(halt1), .busy(busy1), .run_cnt(rc1)
  );

  sopc_reset_seq #(
    .NUM_CH(4), .HOLD_CYCLES(3), .STAGGER(0), .RUN_CYCLES(10), .CNT_W(4)
  ) dut2 (
    .clk(clk), .rst(rst2), .sw_rst_req(sw2), .halt_clr(hc2),
    .rst_out(ro2), .ce(ce2), .halt(halt2), .busy(busy2), .run_cnt(rc2)
  );

  typedef struct {
    int unsigned cyc;
    int unsigned dut;
    string       name;
    logic [3:0]  ro;
    logic        ce;
    logic        hl;
    logic        bz;
    logic [15:0] rc;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  task automatic e1(input int unsigned c, input string nm, input logic [1:0] ro, input logic ce,
                    input logic hl, input logic bz, input logic [15:0] rc);
    exp_t e;
    e.cyc = c; e.dut = 0; e.name = nm; e.ro = {2'b00, ro}; e.ce = ce; e.hl = hl; e.bz = bz; e.rc = rc;
    sbq.push_back(e);
  endtask

  task automatic e2(input int unsigned c, input string nm, input logic [3:0] ro, input logic ce,
                    input logic hl, input logic bz, input logic [3:0] rc);
    exp_t e;
    e.cyc = c; e.dut = 1; e.name = nm; e.ro = ro; e.ce = ce; e.hl = hl; e.bz = bz; e.rc = {12'd0, rc};
    sbq.push_back(e);
  endtask

  task automatic wait_to(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: pops every expectation due at this sample point and compares.
  always @(negedge clk) begin
    exp_t        e;
    logic [3:0]  a_ro;
    logic        a_ce, a_hl, a_bz;
    logic [15:0] a_rc;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.dut == 0) begin
        a_ro = {2'b00, ro1}; a_ce = ce1; a_hl = halt1; a_bz = busy1; a_rc = rc1;
      end else begin
        a_ro = ro2; a_ce = ce2; a_hl = halt2; a_bz = busy2; a_rc = {12'd0, rc2};
      end
      checks++;
      if (e.cyc != cyc || a_ro !== e.ro || a_ce !== e.ce || a_hl !== e.hl || a_bz !== e.bz || a_rc !== e.rc) begin
        errors++;
        $display("FAIL %s (dut%0d cyc %0d, due %0d): got rst_out=%b ce=%b halt=%b busy=%b run_cnt=%0d, want rst_out=%b ce=%b halt=%b busy=%b run_cnt=%0d",
                 e.name, e.dut + 1, cyc, e.cyc, a_ro, a_ce, a_hl, a_bz, a_rc, e.ro, e.ce, e.hl, e.bz, e.rc);
      end
    end
  end

  initial begin
    int unsigned b, h, r, h2, l, p, b3, b4;

    e1(2, "rst_hold_a", 2'b11, 0, 0, 1, 0);
    e2(2, "rst2_hold_a", 4'b1111, 0, 0, 1, 0);
    e1(4, "rst_hold_b", 2'b11, 0, 0, 1, 0);
    e2(4, "rst2_hold_b", 4'b1111, 0, 0, 1, 0);
    wait_to(5);

    // Board reset release and staggered channel release.
    rst1 = 1'b1;
    b = cyc;
    e1(b + 1, "sync_edge1", 2'b11, 0, 0, 1, 0);
    e1(b + 2, "hold_entry", 2'b11, 0, 0, 1, 0);
    e1(b + 6, "pre_rel0", 2'b11, 0, 0, 1, 0);
    e1(b + 7, "rel0", 2'b10, 0, 0, 1, 0);
    e1(b + 8, "pre_rel1", 2'b10, 0, 0, 1, 0);
    e1(b + 9, "rel1_ce", 2'b00, 1, 0, 0, 0);
    e1(b + 10, "run1", 2'b00, 1, 0, 0, 1);
    e1(b + 29, "run20", 2'b00, 1, 0, 0, 20);
    wait_to(b + 29);

    // Software reset pulse at run_cnt=20.
    sw1 = 1'b1;
    h = b + 30;
    r = h + 7;
    e1(h, "swrst", 2'b11, 0, 0, 1, 0);
    e1(h + 4, "sw_pre0", 2'b11, 0, 0, 1, 0);
    e1(h + 5, "sw_rel0", 2'b10, 0, 0, 1, 0);
    e1(h + 6, "sw_pre1", 2'b10, 0, 0, 1, 0);
    e1(r, "sw_rel1", 2'b00, 1, 0, 0, 0);
    e1(r + 49, "run49", 2'b00, 1, 0, 0, 49);
`ifdef RUN_LIMIT_EN
    e1(r + 50, "halt1", 2'b00, 0, 1, 0, 50);
    e1(r + 53, "halt_hold", 2'b00, 0, 1, 0, 50);
    e1(r + 54, "resume", 2'b00, 1, 0, 0, 0);
    e1(r + 55, "resume_run1", 2'b00, 1, 0, 0, 1);
    e1(r + 103, "resume_run49", 2'b00, 1, 0, 0, 49);
    e1(r + 104, "halt2", 2'b00, 0, 1, 0, 50);
`else
    e1(r + 50, "nolimit50", 2'b00, 1, 0, 0, 50);
    e1(r + 53, "nolimit53", 2'b00, 1, 0, 0, 53);
    e1(r + 54, "hc_ignored", 2'b00, 1, 0, 0, 54);
    e1(r + 104, "nolimit104", 2'b00, 1, 0, 0, 104);
`endif
    wait_to(h);
    sw1 = 1'b0;
    wait_to(r + 53);
    hc1 = 1'b1;
    wait_to(r + 54);
    hc1 = 1'b0;
    wait_to(r + 106);

    // sw_rst_req and halt_clr together: software reset wins.
    sw1 = 1'b1;
    hc1 = 1'b1;
    h2 = r + 107;
    e1(h2, "sw_and_hc", 2'b11, 0, 0, 1, 0);
    e1(h2 + 5, "swhc_rel0", 2'b10, 0, 0, 1, 0);
    e1(h2 + 7, "swhc_rel1", 2'b00, 1, 0, 0, 0);
    wait_to(h2);
    sw1 = 1'b0;
    hc1 = 1'b0;
    wait_to(h2 + 10);

    // sw_rst_req held over four edges keeps HOLD restarting.
    sw1 = 1'b1;
    l = h2 + 14;
    e1(h2 + 11, "held_first", 2'b11, 0, 0, 1, 0);
    e1(l, "held_last", 2'b11, 0, 0, 1, 0);
    e1(l + 2, "held_norel", 2'b11, 0, 0, 1, 0);
    e1(l + 4, "held_pre0", 2'b11, 0, 0, 1, 0);
    e1(l + 5, "held_rel0", 2'b10, 0, 0, 1, 0);
    e1(l + 7, "held_rel1", 2'b00, 1, 0, 0, 0);
    wait_to(l);
    sw1 = 1'b0;
    wait_to(l + 10);

    // Asynchronous board reset in the middle of HOLD.
    sw1 = 1'b1;
    p = l + 11;
    e1(p, "pre_async_sw", 2'b11, 0, 0, 1, 0);
    e1(p + 5, "pre_async_rel0", 2'b10, 0, 0, 1, 0);
    wait_to(p);
    sw1 = 1'b0;
    wait_to(p + 5);
    @(posedge clk);
    #2;
    rst1 = 1'b0;
    #1;
    checks++;
    if (ro1 !== 2'b11 || busy1 !== 1'b1 || ce1 !== 1'b0 || halt1 !== 1'b0) begin
      errors++;
      $display("FAIL async_immediate: got rst_out=%b ce=%b halt=%b busy=%b", ro1, ce1, halt1, busy1);
    end
    e1(p + 6, "async_rst", 2'b11, 0, 0, 1, 0);
    wait_to(p + 8);
    rst1 = 1'b1;
    b3 = cyc;
    e1(b3 + 1, "resync1", 2'b11, 0, 0, 1, 0);
    e1(b3 + 6, "resync_pre0", 2'b11, 0, 0, 1, 0);
    e1(b3 + 7, "resync_rel0", 2'b10, 0, 0, 1, 0);
    e1(b3 + 9, "resync_rel1", 2'b00, 1, 0, 0, 0);
    e1(b3 + 12, "resync_run3", 2'b00, 1, 0, 0, 3);
    wait_to(b3 + 15);

    // Four channels, zero stagger, narrow counter.
    rst2 = 1'b1;
    b4 = cyc;
    e2(b4 + 2, "d2_hold_entry", 4'b1111, 0, 0, 1, 0);
    e2(b4 + 4, "d2_pre_rel", 4'b1111, 0, 0, 1, 0);
    e2(b4 + 5, "d2_rel_all", 4'b0000, 1, 0, 0, 0);
    e2(b4 + 6, "d2_run1", 4'b0000, 1, 0, 0, 1);
`ifdef RUN_LIMIT_EN
    e2(b4 + 14, "d2_run9", 4'b0000, 1, 0, 0, 9);
    e2(b4 + 15, "d2_halt", 4'b0000, 0, 1, 0, 10);
`else
    e2(b4 + 20, "d2_run15", 4'b0000, 1, 0, 0, 15);
    e2(b4 + 21, "d2_wrap", 4'b0000, 1, 0, 0, 0);
`endif
    wait_to(b4 + 25);
    @(negedge clk);

    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.name, e.cyc, cyc);
    end

    if (checks < 12) begin
      errors++;
      $display("FAIL too few checks executed: %0d", checks);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
